// File: rtl/msu_pkg.sv
// Shared constants, state encoding and volume scaler for the MSU-1 audio sample stage.
package msu_pkg;

  localparam int unsigned MSU_FIFO_DEPTH = 2048;
  localparam int unsigned MSU_FIFO_AW    = 11;
  localparam int unsigned MSU_HDR_WORDS  = 4;
  localparam int unsigned MSU_USEDW_HI   = 1792;

  typedef enum logic [1:0] {
    IDLE,
    RD_L,
    RD_R,
    OUT
  } msu_stream_state_t;

  // Signed sample times unsigned 8-bit volume, arithmetic >>> 8; 255 is exact passthrough.
  function automatic logic [15:0] msu_scale(input logic [15:0] s, input logic [7:0] vol);
    logic signed [24:0] p;
    p = $signed({{9{s[15]}}, s}) * $signed({17'b0, vol});
    if (vol == 8'hFF) return s;
    return p[23:8];
  endfunction

endpackage

// File: rtl/msu_audio_fifo_ram.sv
// Simple dual-port sample RAM with registered read, inferrable as block RAM.
module msu_audio_fifo_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/msu_audio_stream.sv
// MSU-1 audio sample stage: header strip, 2048-word FIFO, 44.1 kHz fractional tick,
// stereo pop, volume scaling and registered L/R outputs.
module msu_audio_stream
  import msu_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 21477272,
  parameter int unsigned SAMPLE_HZ = 44100,
  parameter int unsigned HDR_WORDS = MSU_HDR_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        sd_ack_1,
  input  logic        sd_buff_wr,
  input  logic [15:0] sd_buff_dout,
  input  logic        ignore_sd_buffer_out,
  input  logic        audio_play,
  input  logic [7:0]  volume,
  output logic [11:0] audio_fifo_usedw,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        sample_strobe,
  output logic        underrun,
  output logic        overflow
);

  msu_stream_state_t state, state_d;

  logic [31:0]            acc;
  logic [31:0]            acc_sum;
  logic                   tick;
  logic [MSU_FIFO_AW-1:0] wptr, rptr;
  logic [11:0]            usedw;
  logic [15:0]            hdr_cnt;
  logic [15:0]            left_q;
  logic [15:0]            rdata;
  logic                   qual, full, wr_ok;
  logic                   rd_issue, cap_l, load_out, zero_out, set_ur, pop;

  assign audio_fifo_usedw = usedw;

  always_comb begin
    acc_sum = acc + 32'(SAMPLE_HZ);
    tick    = (acc_sum >= 32'(CLK_HZ));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  acc <= '0;
    else if (tick) acc <= acc_sum - 32'(CLK_HZ);
    else           acc <= acc_sum;
  end

  always_comb begin
    qual  = sd_ack_1 && sd_buff_wr && !ignore_sd_buffer_out;
    full  = (usedw == 12'(MSU_FIFO_DEPTH));
    wr_ok = qual && (hdr_cnt == '0) && !full && !flush;
  end

  always_comb begin
    state_d  = state;
    rd_issue = 1'b0;
    cap_l    = 1'b0;
    load_out = 1'b0;
    zero_out = 1'b0;
    set_ur   = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          if (!audio_play) begin
            zero_out = 1'b1;
          end else if (usedw >= 12'd2) begin
            rd_issue = 1'b1;
            state_d  = RD_L;
          end else begin
            zero_out = 1'b1;
            set_ur   = 1'b1;
          end
        end
      end
      RD_L: begin
        cap_l    = 1'b1;
        rd_issue = 1'b1;
        pop      = 1'b1;
        state_d  = RD_R;
      end
      RD_R: begin
        // Outputs load on the RD_R->OUT edge so the strobe coincides with the OUT cycle.
        load_out = 1'b1;
        pop      = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   state <= IDLE;
    else if (flush) state <= IDLE;
    else            state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr          <= '0;
      rptr          <= '0;
      usedw         <= '0;
      hdr_cnt       <= 16'(HDR_WORDS);
      left_q        <= '0;
      audio_l       <= '0;
      audio_r       <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      overflow      <= 1'b0;
    end else if (flush) begin
      wptr          <= '0;
      rptr          <= '0;
      usedw         <= '0;
      hdr_cnt       <= 16'(HDR_WORDS);
      audio_l       <= '0;
      audio_r       <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      sample_strobe <= load_out;
      if (qual) begin
        if (hdr_cnt != '0) hdr_cnt  <= hdr_cnt - 16'd1;
        else if (full)     overflow <= 1'b1;
      end
      if (wr_ok)    wptr <= wptr + 1'b1;
      if (rd_issue) rptr <= rptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   usedw <= usedw + 12'd1;
        2'b01:   usedw <= usedw - 12'd1;
        default: usedw <= usedw;
      endcase
      if (cap_l) left_q <= rdata;
      if (load_out) begin
        audio_l <= msu_scale(left_q, volume);
        audio_r <= msu_scale(rdata, volume);
      end else if (zero_out) begin
        audio_l <= '0;
        audio_r <= '0;
      end
      if (set_ur) underrun <= 1'b1;
    end
  end

  msu_audio_fifo_ram #(
    .AW(MSU_FIFO_AW),
    .DW(16)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wptr),
    .wdata(sd_buff_dout),
    .re   (rd_issue),
    .raddr(rptr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_msu_audio_stream.sv
// Directed/randomized bench for msu_audio_stream against a queue-based reference model.
module tb_msu_audio_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        sd_ack_1;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_dout;
  logic        ignore_sd_buffer_out;
  logic        audio_play;
  logic [7:0]  volume;
  logic [11:0] audio_fifo_usedw;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        sample_strobe;
  logic        underrun;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  int          hdr_m;
  logic        ovf_m;

  always #5 clk = ~clk;

  msu_audio_stream dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .flush               (flush),
    .sd_ack_1            (sd_ack_1),
    .sd_buff_wr          (sd_buff_wr),
    .sd_buff_dout        (sd_buff_dout),
    .ignore_sd_buffer_out(ignore_sd_buffer_out),
    .audio_play          (audio_play),
    .volume              (volume),
    .audio_fifo_usedw    (audio_fifo_usedw),
    .audio_l             (audio_l),
    .audio_r             (audio_r),
    .sample_strobe       (sample_strobe),
    .underrun            (underrun),
    .overflow            (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_scale(input logic [15:0] s, input int vol);
    int sv, p, f;
    sv = int'($signed(s));
    if (vol == 255) return s;
    p = sv * vol;
    f = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    return 16'(f);
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic write_word(input logic [15:0] w, input logic ign, input logic ack);
    sd_ack_1 = ack;
    sd_buff_wr = 1'b1;
    sd_buff_dout = w;
    ignore_sd_buffer_out = ign;
    @(negedge clk);
    sd_ack_1 = 1'b0;
    sd_buff_wr = 1'b0;
    ignore_sd_buffer_out = 1'b0;
    if (ack && !ign) begin
      if (hdr_m > 0) hdr_m--;
      else if (q.size() < 2048) q.push_back(w);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    q.delete();
    hdr_m = 4;
    ovf_m = 1'b0;
  endtask

  // Enables play, waits for the next rate tick, then returns at the third negedge after it.
  task automatic wait_tick(output bit seen);
    seen = 1'b0;
    audio_play = 1'b1;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (dut.tick) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      chk("tick_timeout", 32'd0, 32'd1);
      audio_play = 1'b0;
      return;
    end
    @(negedge clk);
    audio_play = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic play_sample(input string tag);
    bit seen;
    logic [15:0] l, r;
    wait_tick(seen);
    if (!seen) return;
    l = q.pop_front();
    r = q.pop_front();
    chk({tag, "_strobe"}, 32'(sample_strobe), 32'd1);
    chk({tag, "_l"}, 32'(audio_l), 32'(ref_scale(l, int'(volume))));
    chk({tag, "_r"}, 32'(audio_r), 32'(ref_scale(r, int'(volume))));
    chk({tag, "_usedw"}, 32'(audio_fifo_usedw), 32'(q.size()));
  endtask

  initial begin
    bit seen;
    int tick_cnt;
    int n;
    logic [15:0] w;
    reset_n = 1'b0;
    flush = 1'b0;
    sd_ack_1 = 1'b0;
    sd_buff_wr = 1'b0;
    sd_buff_dout = '0;
    ignore_sd_buffer_out = 1'b0;
    audio_play = 1'b0;
    volume = 8'hFF;
    hdr_m = 4;
    ovf_m = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_usedw", 32'(audio_fifo_usedw), 32'd0);
    chk("rst_l", 32'(audio_l), 32'd0);
    chk("rst_r", 32'(audio_r), 32'd0);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Tick count over a window starting at reset release: floor(N*SAMPLE_HZ/CLK_HZ).
    reset_n = 1'b1;
    tick_cnt = 0;
    for (int i = 0; i < 30000; i++) begin
      if (dut.tick) tick_cnt++;
      @(negedge clk);
    end
    chk("tick_count", 32'(tick_cnt), 32'((longint'(30000) * 44100) / 21477272));

    // Header strip and basic stereo pop.
    do_flush();
    for (int i = 1; i <= 6; i++) begin
      w = 16'(i * 16'h1111);
      write_word(w, 1'b0, 1'b1);
    end
    chk("hdr_usedw", 32'(audio_fifo_usedw), 32'd2);
    volume = 8'hFF;
    play_sample("basic");
    chk("basic_l_const", 32'(audio_l), 32'h5555);
    chk("basic_r_const", 32'(audio_r), 32'h6666);

    // Ignored and unacknowledged words neither stored nor counted against the header.
    do_flush();
    for (int i = 0; i < 16; i++) begin
      write_word(16'($urandom), (i % 3 == 1) || ($urandom_range(3) == 0), (i % 5 != 4));
    end
    chk("ign_usedw", 32'(audio_fifo_usedw), 32'(q.size()));
    n = 0;
    while (q.size() >= 2 && n < 3) begin
      play_sample("ign");
      n++;
    end

    // Volume scaling.
    do_flush();
    for (int i = 0; i < 4; i++) write_word(16'($urandom), 1'b0, 1'b1);
    write_word(16'h4000, 1'b0, 1'b1);
    write_word(16'h8000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) write_word(16'($urandom), 1'b0, 1'b1);
    write_word(16'h1234, 1'b0, 1'b1);
    write_word(16'h5678, 1'b0, 1'b1);
    volume = 8'd128;
    play_sample("vol128");
    chk("vol128_l_const", 32'(audio_l), 32'h2000);
    chk("vol128_r_const", 32'(audio_r), 32'hC000);
    volume = 8'd0;
    play_sample("vol0");
    for (int i = 0; i < 4; i++) begin
      volume = 8'($urandom_range(254, 1));
      play_sample("volrnd");
    end
    volume = 8'hFF;
    play_sample("vol255");

    // Reset asserted during RD_R.
    write_word(16'h0ABC, 1'b0, 1'b1);
    write_word(16'h0DEF, 1'b0, 1'b1);
    audio_play = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (dut.tick) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("rst_mid_tick_timeout", 32'd0, 32'd1);
    @(negedge clk);
    audio_play = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstmid_l", 32'(audio_l), 32'd0);
    chk("rstmid_r", 32'(audio_r), 32'd0);
    chk("rstmid_usedw", 32'(audio_fifo_usedw), 32'd0);
    chk("rstmid_strobe", 32'(sample_strobe), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    hdr_m = 4;
    @(negedge clk);

    // Underrun with a single buffered word.
    do_flush();
    for (int i = 0; i < 5; i++) write_word(16'($urandom_range(16'hFFFF, 1)), 1'b0, 1'b1);
    wait_tick(seen);
    if (seen) begin
      chk("ur_strobe", 32'(sample_strobe), 32'd0);
      chk("ur_l", 32'(audio_l), 32'd0);
      chk("ur_r", 32'(audio_r), 32'd0);
      chk("ur_flag", 32'(underrun), 32'd1);
      chk("ur_usedw", 32'(audio_fifo_usedw), 32'd1);
    end
    do_flush();
    chk("ur_flush_clear", 32'(underrun), 32'd0);

    // Overflow: 2050 data words after the header.
    for (int i = 0; i < 4 + 2050; i++) write_word(16'($urandom), 1'b0, 1'b1);
    chk("ovf_usedw", 32'(audio_fifo_usedw), 32'd2048);
    chk("ovf_flag", 32'(overflow), 32'(ovf_m));
    chk("ovf_flag_const", 32'(overflow), 32'd1);
    volume = 8'hFF;
    play_sample("ovf_pop0");
    play_sample("ovf_pop1");
    write_word(16'h7E57, 1'b0, 1'b1);
    chk("ovf_refill_usedw", 32'(audio_fifo_usedw), 32'(q.size()));
    do_flush();
    chk("ovf_flush_clear", 32'(overflow), 32'd0);
    chk("flush_usedw", 32'(audio_fifo_usedw), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
